// File: rtl/arm_imm_pkg.sv
// ============================================================================
// Package     : arm_imm_pkg
// Description : Shared types, constants and rotate helper for the ARM
//               data-processing immediate encoder.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package arm_imm_pkg;

    // Search FSM states
    typedef enum logic [0:0] {
        IDLE   = 1'b0,
        SEARCH = 1'b1
    } state_t;

    localparam int ROT_COUNT = 16;
    localparam int ROT_W     = 4;
    localparam int IMM_W     = 8;

    // Last rotation index tried before declaring the constant unencodable
    localparam logic [ROT_W-1:0] ROT_LAST = ROT_W'(ROT_COUNT - 1);

    // Rotate a 32-bit word left by amt (0..31) bit positions
    function automatic logic [31:0] rol32(input logic [31:0] value, input logic [4:0] amt);
        logic [63:0] w_dbl;
        w_dbl = {value, value} << amt;
        return w_dbl[63:32];
    endfunction

endpackage : arm_imm_pkg

`default_nettype wire

// File: rtl/arm_imm_encoder_imm_rot_check.sv
// ============================================================================
// Module      : imm_rot_check
// Description : Tests one rotation candidate. Rotating the constant left by
//               2*rot undoes the decoder's right rotation; the candidate hits
//               when only the low 8 bits remain populated.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module imm_rot_check
    import arm_imm_pkg::*;
(
    input  logic [31:0]      value,
    input  logic [ROT_W-1:0] rot,
    output logic             hit,
    output logic [IMM_W-1:0] imm8
);

    logic [31:0] w_cand;

    // Candidate word and hit decision for this rotation
    always_comb begin
        w_cand = rol32(value, {rot, 1'b0});
        hit    = (w_cand[31:IMM_W] == '0);
        imm8   = w_cand[IMM_W-1:0];
    end

endmodule : imm_rot_check

`default_nettype wire

// File: rtl/arm_imm_encoder.sv
// ============================================================================
// Module      : arm_imm_encoder
// Description : Finds the canonical {imm_rotate, imm_8} encoding of a 32-bit
//               constant (smallest rotation wins) or flags it unencodable.
//               Default build: iterative search, one rotation per cycle.
//               Define ARM_IMM_ENCODER_PARALLEL_EN for a single-cycle
//               parallel search over all 16 rotations.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module arm_imm_encoder
    import arm_imm_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [31:0]      value,
    output logic             busy,
    output logic             done,
    output logic             found,
    output logic [ROT_W-1:0] imm_rotate,
    output logic [IMM_W-1:0] imm_8
);

    logic             r_done;
    logic             r_found;
    logic [ROT_W-1:0] r_imm_rotate;
    logic [IMM_W-1:0] r_imm_8;

`ifdef ARM_IMM_ENCODER_PARALLEL_EN

    logic [ROT_COUNT-1:0] w_hit;
    logic [IMM_W-1:0]     w_imm8 [ROT_COUNT];
    logic                 w_any;
    logic [ROT_W-1:0]     w_sel_rot;
    logic [IMM_W-1:0]     w_sel_imm;

    genvar gi;
    generate
        for (gi = 0; gi < ROT_COUNT; gi++) begin : g_cand
            imm_rot_check u_check (
                .value (value),
                .rot   (ROT_W'(gi)),
                .hit   (w_hit[gi]),
                .imm8  (w_imm8[gi])
            );
        end
    endgenerate

    // Priority select: scan downward so the smallest hitting rotation wins
    always_comb begin
        w_any     = 1'b0;
        w_sel_rot = '0;
        w_sel_imm = '0;
        for (int i = ROT_COUNT - 1; i >= 0; i--) begin
            if (w_hit[i]) begin
                w_any     = 1'b1;
                w_sel_rot = ROT_W'(i);
                w_sel_imm = w_imm8[i];
            end
        end
    end

    // Register the selected encoding on the start cycle; done follows one cycle later
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_done       <= 1'b0;
            r_found      <= 1'b0;
            r_imm_rotate <= '0;
            r_imm_8      <= '0;
        end else begin
            r_done <= 1'b0;
            if (start) begin
                r_done       <= 1'b1;
                r_found      <= w_any;
                r_imm_rotate <= w_sel_rot;
                r_imm_8      <= w_sel_imm;
            end
        end
    end

    assign busy = 1'b0;

`else

    state_t           r_state;
    logic [ROT_W-1:0] r_rot;
    logic [31:0]      r_value;
    logic             w_hit;
    logic [IMM_W-1:0] w_imm8;

    imm_rot_check u_check (
        .value (r_value),
        .rot   (r_rot),
        .hit   (w_hit),
        .imm8  (w_imm8)
    );

    // Search FSM: capture on start, try one rotation per cycle, report first hit or a miss
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= IDLE;
            r_rot        <= '0;
            r_value      <= '0;
            r_done       <= 1'b0;
            r_found      <= 1'b0;
            r_imm_rotate <= '0;
            r_imm_8      <= '0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (start) begin
                        r_value <= value;
                        r_rot   <= '0;
                        r_state <= SEARCH;
                    end
                end
                SEARCH: begin
                    if (w_hit) begin
                        r_found      <= 1'b1;
                        r_imm_rotate <= r_rot;
                        r_imm_8      <= w_imm8;
                        r_done       <= 1'b1;
                        r_state      <= IDLE;
                    end else if (r_rot == ROT_LAST) begin
                        r_found      <= 1'b0;
                        r_imm_rotate <= '0;
                        r_imm_8      <= '0;
                        r_done       <= 1'b1;
                        r_state      <= IDLE;
                    end else begin
                        r_rot <= r_rot + 1'b1;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign busy = (r_state == SEARCH);

`endif

    assign done       = r_done;
    assign found      = r_found;
    assign imm_rotate = r_imm_rotate;
    assign imm_8      = r_imm_8;

endmodule : arm_imm_encoder

`default_nettype wire
